// File: rtl/fwd_scoreboard_unit_if.sv
// Handshake bundle between the ID stage and the forwarding/hazard scoreboard.
// The ID stage drives instruction and control fields; the unit returns selects, stall and count.
interface fwd_scoreboard_unit_if #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned DEPTH   = 3,
   parameter int unsigned LAT_W   = 2,
   parameter int unsigned CNT_W   = 16
);
   logic                         id_valid;
   logic [NUM_SRC*AW-1:0]        id_src_addr;
   logic [NUM_SRC-1:0]           id_src_used;
   logic [AW-1:0]                id_rd;
   logic                         id_we;
   logic [LAT_W-1:0]             id_avail;
   logic                         hold;
   logic [DEPTH-1:0]             flush_mask;
   logic [NUM_SRC*(DEPTH+1)-1:0] fwd_sel;
   logic                         stall;
   logic [CNT_W-1:0]             stall_cycles;

   modport master (
      output id_valid, id_src_addr, id_src_used, id_rd, id_we, id_avail, hold, flush_mask,
      input  fwd_sel, stall, stall_cycles
   );

   modport slave (
      input  id_valid, id_src_addr, id_src_used, id_rd, id_we, id_avail, hold, flush_mask,
      output fwd_sel, stall, stall_cycles
   );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// ID-stage forwarding/hazard unit: shift scoreboard of in-flight writes, one-hot bypass
// selects per source operand, load-use stall and a saturating stall-cycle counter.
module fwd_scoreboard_unit #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned DEPTH   = 3,
   parameter int unsigned LAT_W   = 2,
   parameter int unsigned CNT_W   = 16
) (
   input logic                  i_clk,
   input logic                  i_rst,
   fwd_scoreboard_unit_if.slave sb
);

   localparam int unsigned SelW = DEPTH + 1;

   logic [DEPTH-1:0]         r_valid;
   logic [DEPTH-1:0]         r_we;
   logic [AW-1:0]            r_rd    [DEPTH];
   logic [LAT_W-1:0]         r_avail [DEPTH];
   logic [CNT_W-1:0]         r_stall_cnt;

   logic [DEPTH-1:0]         w_prod;
   logic [NUM_SRC-1:0]       w_src_stall;
   logic [NUM_SRC*SelW-1:0]  w_fwd_sel;
   logic                     w_stall;
   logic                     w_issue;

   always_comb begin
      for (int k = 0; k < int'(DEPTH); k++) begin
         w_prod[k] = r_valid[k] & r_we[k] & (r_rd[k] != '0);
      end
   end

   // Only the youngest matching producer is considered; if it is not ready we stall
   // rather than fall back to an older, stale copy.
   always_comb begin : sel_comb
      logic [AW-1:0] v_src;
      logic          v_found;
      w_fwd_sel   = '0;
      w_src_stall = '0;
      v_src       = '0;
      v_found     = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         v_src                  = sb.id_src_addr[i*int'(AW) +: AW];
         v_found                = 1'b0;
         w_fwd_sel[i*int'(SelW)] = 1'b1;
         if (sb.id_valid && sb.id_src_used[i] && (v_src != '0)) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
               if (!v_found && w_prod[k] && (r_rd[k] == v_src)) begin
                  v_found = 1'b1;
                  if (k >= int'(r_avail[k])) begin
                     w_fwd_sel[i*int'(SelW)]       = 1'b0;
                     w_fwd_sel[i*int'(SelW) + k + 1] = 1'b1;
                  end else begin
                     w_src_stall[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign w_stall = |w_src_stall;
   assign w_issue = sb.id_valid & ~w_stall & ~sb.flush_mask[0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid     <= '0;
         r_we        <= '0;
         r_stall_cnt <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_rd[k]    <= '0;
            r_avail[k] <= '0;
         end
      end else begin
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (sb.hold) begin
            // Frozen backend: flushed entries become bubbles in place.
            r_valid <= r_valid & ~sb.flush_mask;
         end else begin
            r_valid[0] <= w_issue;
            r_we[0]    <= sb.id_we;
            r_rd[0]    <= sb.id_rd;
            r_avail[0] <= sb.id_avail;
            for (int k = 1; k < int'(DEPTH); k++) begin
               r_valid[k] <= r_valid[k-1] & ~sb.flush_mask[k-1];
               r_we[k]    <= r_we[k-1];
               r_rd[k]    <= r_rd[k-1];
               r_avail[k] <= r_avail[k-1];
            end
         end
      end
   end

   assign sb.fwd_sel      = w_fwd_sel;
   assign sb.stall        = w_stall;
   assign sb.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench for fwd_scoreboard_unit: directed scenarios plus random traffic, checked
// against an entry-list reference model by a decoupled monitor.
module tb_fwd_scoreboard_unit;

   localparam int NS = 2, AW = 5, D = 3, LW = 2, CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_scoreboard_unit_if #(.NUM_SRC(NS), .AW(AW), .DEPTH(D), .LAT_W(LW), .CNT_W(CW)) sb_if ();

   fwd_scoreboard_unit #(.NUM_SRC(NS), .AW(AW), .DEPTH(D), .LAT_W(LW), .CNT_W(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .sb    (sb_if)
   );

   typedef struct {
      bit v;
      int rd;
      bit we;
      int av;
   } ent_t;

   typedef struct {
      logic [7:0]  sel;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;

   ent_t m_st [D];
   int   m_cnt;
   bit   m_stall;
   exp_t exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: youngest matching writer decides; forward once its stage reaches avail.
   function automatic void model_eval(output logic [7:0] sel, output logic stl);
      int src;
      stl = 1'b0;
      sel = 8'h11;
      for (int i = 0; i < NS; i++) begin
         src = int'(sb_if.id_src_addr[i*AW +: AW]);
         if (sb_if.id_valid && sb_if.id_src_used[i] && src != 0) begin
            for (int k = 0; k < D; k++) begin
               if (m_st[k].v && m_st[k].we && m_st[k].rd != 0 && m_st[k].rd == src) begin
                  if (k >= m_st[k].av) sel[i*4 +: 4] = 4'(1 << (k + 1));
                  else stl = 1'b1;
                  break;
               end
            end
         end
      end
   endfunction

   task automatic model_clear();
      for (int k = 0; k < D; k++) m_st[k] = '{v: 0, rd: 0, we: 0, av: 0};
      m_cnt   = 0;
      m_stall = 0;
   endtask

   task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                        input int rd, input bit we, input int av, input bit hold,
                        input bit [2:0] fl);
      exp_t e;
      @(negedge clk);
      sb_if.id_valid    = v;
      sb_if.id_src_addr = {5'(s1), 5'(s0)};
      sb_if.id_src_used = used;
      sb_if.id_rd       = 5'(rd);
      sb_if.id_we       = we;
      sb_if.id_avail    = 2'(av);
      sb_if.hold        = hold;
      sb_if.flush_mask  = fl;
      model_eval(e.sel, e.stall);
      e.cnt   = 16'(m_cnt);
      m_stall = e.stall;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      ent_t nw;
      @(posedge clk);
      if (m_stall && m_cnt != 16'hFFFF) m_cnt++;
      for (int k = 0; k < D; k++) if (sb_if.flush_mask[k]) m_st[k].v = 0;
      if (!sb_if.hold) begin
         nw.v  = sb_if.id_valid && !m_stall && !sb_if.flush_mask[0];
         nw.rd = int'(sb_if.id_rd);
         nw.we = sb_if.id_we;
         nw.av = int'(sb_if.id_avail);
         for (int k = D - 1; k > 0; k--) m_st[k] = m_st[k-1];
         m_st[0] = nw;
      end
   endtask

   task automatic idle_inputs();
      sb_if.id_valid    = 0;
      sb_if.id_src_addr = '0;
      sb_if.id_src_used = '0;
      sb_if.id_rd       = '0;
      sb_if.id_we       = 0;
      sb_if.id_avail    = '0;
      sb_if.hold        = 0;
      sb_if.flush_mask  = '0;
   endtask

   // Reset asserted mid-cycle, after the monitor has consumed this cycle's expectation.
   task automatic do_reset(input bit check);
      @(negedge clk);
      #3;
      rst = 1'b1;
      idle_inputs();
      model_clear();
      #1;
      if (check) begin
         chk("rst_fwd_sel", 32'(sb_if.fwd_sel), 32'h11);
         chk("rst_stall", 32'(sb_if.stall), 32'h0);
         chk("rst_stall_cycles", 32'(sb_if.stall_cycles), 32'h0);
      end
      @(negedge clk);
      #3;
      rst = 1'b0;
   endtask

   // Monitor: output is presented every cycle; compare mid low phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_fwd_sel", 32'(sb_if.fwd_sel), 32'(e.sel));
            chk("mon_stall", 32'(sb_if.stall), 32'(e.stall));
            chk("mon_stall_cycles", 32'(sb_if.stall_cycles), 32'(e.cnt));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset mid-stream with three valid entries.
      drive(1, 0, 0, 0, 5, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 6, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0); tick();
      do_reset(1);
      drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
      #1 chk("t1_after_rst_sel", 32'(sb_if.fwd_sel), 32'h11);
      tick();

      // ALU result walks down the bypass stages.
      do_reset(0);
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0); tick();
      for (int c = 0; c < 4; c++) begin
         logic [3:0] want;
         want = (c == 3) ? 4'b0001 : 4'(2 << c);
         drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0);
         #1 chk("t2_sel0", 32'(sb_if.fwd_sel[3:0]), 32'(want));
         chk("t2_stall", 32'(sb_if.stall), 32'h0);
         tick();
      end

      // Load-use on src1: two stalls then MEM/WB bypass.
      do_reset(0);
      drive(1, 0, 0, 0, 5, 1, 2, 0, 0); tick();
      for (int c = 0; c < 3; c++) begin
         drive(1, 0, 5, 2'b10, 0, 0, 0, 0, 0);
         #1 chk("t3_stall", 32'(sb_if.stall), (c < 2) ? 32'h1 : 32'h0);
         if (c == 2) begin
            chk("t3_sel1", 32'(sb_if.fwd_sel[7:4]), 32'h8);
            chk("t3_cnt", 32'(sb_if.stall_cycles), 32'h2);
         end
         tick();
      end

      // Youngest producer wins; r0 never forwards.
      do_reset(0);
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0); tick();
      drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
      #1 chk("t4_youngest", 32'(sb_if.fwd_sel[3:0]), 32'h2);
      tick();
      do_reset(0);
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 2'b01, 0, 0, 0, 0, 0);
      #1 chk("t4_r0_sel", 32'(sb_if.fwd_sel), 32'h11);
      chk("t4_r0_stall", 32'(sb_if.stall), 32'h0);
      tick();

      // Flush stage 0 while an ID write to r9 is cancelled.
      do_reset(0);
      drive(1, 0, 0, 0, 5, 1, 2, 0, 0); tick();
      drive(1, 0, 0, 0, 9, 1, 0, 0, 3'b001); tick();
      drive(1, 5, 9, 2'b11, 0, 0, 0, 0, 0);
      #1 chk("t5_sel", 32'(sb_if.fwd_sel), 32'h11);
      chk("t5_stall", 32'(sb_if.stall), 32'h0);
      tick();

      // Hold freezes a stalled load-use, then it drains normally.
      do_reset(0);
      drive(1, 0, 0, 0, 5, 1, 2, 0, 0); tick();
      for (int c = 0; c < 6; c++) begin
         drive(1, 5, 0, 2'b01, 0, 0, 0, (c < 3), 0);
         #1 chk("t6_cnt", 32'(sb_if.stall_cycles), 32'(c > 5 ? 5 : c));
         chk("t6_stall", 32'(sb_if.stall), (c < 5) ? 32'h1 : 32'h0);
         chk("t6_sel", 32'(sb_if.fwd_sel), (c < 5) ? 32'h11 : 32'h18);
         tick();
      end

      // Random traffic over a small register set to provoke hazards.
      do_reset(0);
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 4) == 0,
               ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
         tick();
      end

      @(negedge clk);
      #4;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
